i2c_master_fsm: RTL and testbench

Clocked I2C master that runs one complete bus transaction: START, 7-bit address plus R/W, two data bytes written or read, then STOP. It generates SCL from the system clock and drives both bus lines open-drain through output enables. It is the initiator for the team's two-byte I2C slave, and it reports completion and NACK status to a host through a start/busy/done handshake.

---
 rtl/i2c_pkg.sv | 27 ++
 rtl/i2c_phase_gen.sv | 63 ++++++
 rtl/i2c_master_fsm.sv | 204 ++++++++++++++++++++
 tb/tb_i2c_master_fsm.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types for the I2C master: FSM states, bit-cell quarter-phases and default widths.
// Used by i2c_phase_gen and i2c_master_fsm (optional clock stretching: I2C_MASTER_CLK_STRETCH_EN).
package i2c_pkg;

  localparam int I2C_ADDR_LEN = 7;
  localparam int I2C_DATA_LEN = 8;

  typedef enum logic [3:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    STOP
  } i2c_state_e;

  typedef enum logic [1:0] {
    Q0,
    Q1,
    Q2,
    Q3
  } i2c_phase_e;

endpackage

// File: rtl/i2c_phase_gen.sv
// Divides clk into SCL quarter-phases Q0..Q3 and strobes the end of each quarter and bit cell.
// With I2C_MASTER_CLK_STRETCH_EN defined, Q2 timing is held while the slave keeps SCL low.
module i2c_phase_gen
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       scl_in,
  output i2c_phase_e phase_o,
  output logic       q_end_o,
  output logic       phase_end_o
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] DIV_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_q, div_d;
  i2c_phase_e    phase_q, phase_d;
  logic          hold;

`ifdef I2C_MASTER_CLK_STRETCH_EN
  // SCL is released in Q2; a low line means the slave is stretching, so restart Q2 timing.
  assign hold = (phase_q == Q2) && !scl_in;
`else
  logic unused_scl_in;
  assign unused_scl_in = scl_in;
  assign hold = 1'b0;
`endif

  assign phase_o     = phase_q;
  assign q_end_o     = en && !hold && (div_q == DIV_MAX);
  assign phase_end_o = q_end_o && (phase_q == Q3);

  always_comb begin
    div_d   = div_q;
    phase_d = phase_q;
    if (!en) begin
      div_d   = '0;
      phase_d = Q0;
    end else if (hold) begin
      div_d = '0;
    end else if (div_q == DIV_MAX) begin
      div_d   = '0;
      phase_d = i2c_phase_e'(phase_q + 2'd1);
    end else begin
      div_d = div_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      phase_q <= Q0;
    end else begin
      div_q   <= div_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/i2c_master_fsm.sv
// Single-transaction I2C master: START, address+R/W, two data bytes, STOP, open-drain outputs.
// Define I2C_MASTER_CLK_STRETCH_EN to let a slave stretch SCL during the high phase.
module i2c_master_fsm
  import i2c_pkg::*;
#(
  parameter int ADDR_LEN = I2C_ADDR_LEN,
  parameter int DATA_LEN = I2C_DATA_LEN,
  parameter int CLK_DIV  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                rw,
  input  logic [ADDR_LEN-1:0] addr,
  input  logic [DATA_LEN-1:0] wr_data1,
  input  logic [DATA_LEN-1:0] wr_data2,
  output logic [DATA_LEN-1:0] rd_data1,
  output logic [DATA_LEN-1:0] rd_data2,
  output logic                busy,
  output logic                done,
  output logic                nack,
  output logic                scl_oe,
  output logic                sda_oe,
  input  logic                scl_in,
  input  logic                sda_in
);

  i2c_state_e          state_q, state_d;
  logic [2:0]          bit_q, bit_d;
  logic                byte_q, byte_d;
  logic [DATA_LEN-1:0] shift_q, shift_d;
  logic                rw_q, rw_d;
  logic [ADDR_LEN-1:0] addr_q, addr_d;
  logic [DATA_LEN-1:0] wr1_q, wr1_d, wr2_q, wr2_d;
  logic [DATA_LEN-1:0] rd1_q, rd1_d, rd2_q, rd2_d;
  logic                nack_q, nack_d, busy_q, busy_d, done_q, done_d;

  i2c_phase_e phase;
  logic       q_end, phase_end, sample, low_half;

  i2c_phase_gen #(.CLK_DIV(CLK_DIV)) u_phase_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (state_q != IDLE),
    .scl_in     (scl_in),
    .phase_o    (phase),
    .q_end_o    (q_end),
    .phase_end_o(phase_end)
  );

  assign sample   = q_end && (phase == Q2);
  assign low_half = (phase == Q0) || (phase == Q1);

  assign rd_data1 = rd1_q;
  assign rd_data2 = rd2_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign nack     = nack_q;

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shift_d = shift_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wr1_d   = wr1_q;
    wr2_d   = wr2_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    nack_d  = nack_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        rw_d    = rw;
        addr_d  = addr;
        wr1_d   = wr_data1;
        wr2_d   = wr_data2;
        nack_d  = 1'b0;
        busy_d  = 1'b1;
        state_d = START;
      end
      START: if (phase_end) begin
        state_d = ADDR;
        bit_d   = 3'd7;
        byte_d  = 1'b0;
        shift_d = {addr_q, rw_q};
      end
      ADDR, WR_DATA: if (phase_end) begin
        if (bit_q == 3'd0) begin
          state_d = (state_q == ADDR) ? ADDR_ACK : WR_ACK;
        end else begin
          bit_d   = bit_q - 3'd1;
          shift_d = shift_q << 1;
        end
      end
      ADDR_ACK: begin
        if (sample && sda_in) nack_d = 1'b1;
        if (phase_end) begin
          bit_d = 3'd7;
          if (nack_q)    state_d = STOP;
          else if (rw_q) state_d = RD_DATA;
          else begin
            state_d = WR_DATA;
            shift_d = wr1_q;
          end
        end
      end
      WR_ACK: begin
        if (sample && sda_in) nack_d = 1'b1;
        if (phase_end) begin
          if (nack_q || byte_q) state_d = STOP;
          else begin
            state_d = WR_DATA;
            byte_d  = 1'b1;
            bit_d   = 3'd7;
            shift_d = wr2_q;
          end
        end
      end
      RD_DATA: begin
        if (sample) shift_d = {shift_q[DATA_LEN-2:0], sda_in};
        if (phase_end) begin
          if (bit_q == 3'd0) state_d = RD_ACK;
          else               bit_d   = bit_q - 3'd1;
        end
      end
      RD_ACK: if (phase_end) begin
        if (!byte_q) begin
          rd1_d   = shift_q;
          byte_d  = 1'b1;
          bit_d   = 3'd7;
          state_d = RD_DATA;
        end else begin
          rd2_d   = shift_q;
          state_d = STOP;
        end
      end
      STOP: if (phase_end) begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Line drive is decoded from state so an asynchronous reset releases the bus at once.
  always_comb begin
    scl_oe = 1'b0;
    sda_oe = 1'b0;
    case (state_q)
      IDLE:  ;
      START: sda_oe = !low_half;
      ADDR, WR_DATA: begin
        scl_oe = low_half;
        sda_oe = !shift_q[DATA_LEN-1];
      end
      RD_ACK: begin
        scl_oe = low_half;
        sda_oe = !byte_q;
      end
      STOP: begin
        scl_oe = low_half;
        sda_oe = (phase != Q3);
      end
      default: scl_oe = low_half;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bit_q   <= 3'd0;
      byte_q  <= 1'b0;
      shift_q <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wr1_q   <= '0;
      wr2_q   <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      nack_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shift_q <= shift_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wr1_q   <= wr1_d;
      wr2_q   <= wr2_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      nack_q  <= nack_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_i2c_master_fsm.sv
// Self-checking bench for i2c_master_fsm: directed and random transactions against a bus-level model.
// The stretch case expects a 50-cycle extension only when I2C_MASTER_CLK_STRETCH_EN is defined.
module tb_i2c_master_fsm;

  localparam int DIV = 4;
  localparam int BIT = 4 * DIV;
`ifdef I2C_MASTER_CLK_STRETCH_EN
  localparam int STRETCH_EXT = 50;
`else
  localparam int STRETCH_EXT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] addr = '0;
  logic [7:0] wr_data1 = '0, wr_data2 = '0;
  logic [7:0] rd_data1, rd_data2;
  logic       busy, done, nack, scl_oe, sda_oe;
  logic       scl_in, sda_in;

  logic       slave_low = 1'b0;
  logic       stretch_low = 1'b0;
  logic       mon_clr = 1'b0;
  logic       scl_bus, sda_bus;
  logic       plan [32];
  logic [31:0] obs_bits = '0;
  int         obs_cnt = 0;
  int         fall_idx = 0;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  int         txn_no = 0;
  logic [7:0] model_rd1 = '0, model_rd2 = '0;

  assign scl_bus = !scl_oe;
  assign sda_bus = !(sda_oe || slave_low);
  assign scl_in  = scl_bus && !stretch_low;
  assign sda_in  = sda_bus;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  i2c_master_fsm #(.ADDR_LEN(7), .DATA_LEN(8), .CLK_DIV(DIV)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .rw      (rw),
    .addr    (addr),
    .wr_data1(wr_data1),
    .wr_data2(wr_data2),
    .rd_data1(rd_data1),
    .rd_data2(rd_data2),
    .busy    (busy),
    .done    (done),
    .nack    (nack),
    .scl_oe  (scl_oe),
    .sda_oe  (sda_oe),
    .scl_in  (scl_in),
    .sda_in  (sda_in)
  );

  // Slave model: records SDA on every SCL rise, applies its drive plan on every SCL fall.
  always @(scl_bus or posedge mon_clr) begin
    if (mon_clr) begin
      obs_bits  = '0;
      obs_cnt   = 0;
      fall_idx  = 0;
      slave_low = 1'b0;
    end else if (scl_bus) begin
      obs_bits = {obs_bits[30:0], sda_bus};
      obs_cnt  = obs_cnt + 1;
    end else begin
      slave_low = (fall_idx < 32) ? plan[fall_idx] : 1'b0;
      fall_idx  = fall_idx + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_monitor();
    for (int i = 0; i < 32; i++) plan[i] = 1'b0;
    mon_clr = 1'b1;
    #1 mon_clr = 1'b0;
  endtask

  task automatic run_txn(input logic t_rw, input logic [6:0] t_addr, input logic [7:0] b1,
                         input logic [7:0] b2, input bit ack_a, input bit ack_1, input bit ack_2,
                         input bit poke, input bit stretch);
    logic [31:0] exp_bits;
    logic [7:0]  abyte;
    int          exp_n, periods, ext, t_acc, dur;
    bit          exp_nack, seen;
    clear_monitor();
    exp_bits = '0;
    exp_n    = 0;
    abyte    = {t_addr, t_rw};
    for (int i = 7; i >= 0; i--) begin exp_bits = {exp_bits[30:0], abyte[i]}; exp_n++; end
    plan[8]  = ack_a;
    exp_bits = {exp_bits[30:0], !ack_a}; exp_n++;
    exp_nack = !ack_a;
    if (ack_a && !t_rw) begin
      for (int i = 7; i >= 0; i--) begin exp_bits = {exp_bits[30:0], b1[i]}; exp_n++; end
      plan[17] = ack_1;
      exp_bits = {exp_bits[30:0], !ack_1}; exp_n++;
      if (!ack_1) exp_nack = 1'b1;
      else begin
        for (int i = 7; i >= 0; i--) begin exp_bits = {exp_bits[30:0], b2[i]}; exp_n++; end
        plan[26] = ack_2;
        exp_bits = {exp_bits[30:0], !ack_2}; exp_n++;
        exp_nack = !ack_2;
      end
    end else if (ack_a) begin
      for (int i = 0; i < 8; i++) begin
        plan[9 + i]  = !b1[7 - i];
        plan[18 + i] = !b2[7 - i];
        exp_bits = {exp_bits[30:0], b1[7 - i]}; exp_n++;
      end
      exp_bits = {exp_bits[30:0], 1'b0}; exp_n++;
      for (int i = 7; i >= 0; i--) begin exp_bits = {exp_bits[30:0], b2[i]}; exp_n++; end
      exp_bits = {exp_bits[30:0], 1'b1}; exp_n++;
      model_rd1 = b1;
      model_rd2 = b2;
    end
    exp_bits = {exp_bits[30:0], 1'b0}; exp_n++;   // SCL rise inside STOP sees SDA low
    periods  = exp_n + 1;                          // START has no SCL rise
    ext      = stretch ? STRETCH_EXT : 0;

    @(negedge clk);
    rw = t_rw; addr = t_addr; wr_data1 = t_rw ? 8'h00 : b1; wr_data2 = t_rw ? 8'h00 : b2;
    start = 1'b1;
    t_acc = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    rw = $urandom_range(0, 1); addr = 7'($urandom); wr_data1 = 8'($urandom); wr_data2 = 8'($urandom);
    check_eq("busy_rise", busy, 1);

    if (poke) begin
      repeat (20) @(negedge clk);
      start = 1'b1; rw = !t_rw; addr = ~t_addr; wr_data1 = ~b1; wr_data2 = ~b2;
      @(negedge clk);
      start = 1'b0;
    end
    if (stretch) begin
      seen = 0;
      for (int k = 0; k < 8 * BIT && !seen; k++) begin
        @(negedge clk);
        if (fall_idx == 4 && !scl_oe) seen = 1;
      end
      check_eq("stretch_reach", seen, 1);
      stretch_low = 1'b1;
      repeat (50) @(posedge clk);
      @(negedge clk);
      stretch_low = 1'b0;
    end

    seen = 0;
    for (int k = 0; k < periods * BIT + ext + 100 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    if (!seen) begin
      check_eq("done_timeout", 0, 1);
      return;
    end
    dur = cyc - t_acc;
    if (!t_rw && !ack_a) model_rd1 = model_rd1;   // NACK-aborted transfers leave read data alone
    check_eq("duration", dur, periods * BIT + ext);
    check_eq("nack", nack, exp_nack);
    check_eq("busy_fall", busy, 0);
    check_eq("bit_count", obs_cnt, exp_n);
    check_eq("bus_bits", obs_bits, exp_bits);
    check_eq("rd_data1", rd_data1, model_rd1);
    check_eq("rd_data2", rd_data2, model_rd2);
    $display("txn %0d rw=%0d addr=%02h b1=%02h b2=%02h acks=%0d%0d%0d dur=%0d nack=%0d rd=%02h/%02h",
             txn_no, t_rw, t_addr, b1, b2, ack_a, ack_1, ack_2, dur, nack, rd_data1, rd_data2);
    txn_no++;
    @(negedge clk);
    check_eq("done_pulse", done, 0);
  endtask

  task automatic reset_mid();
    bit seen;
    clear_monitor();
    plan[8] = 1'b1;
    @(negedge clk);
    rw = 1'b0; addr = 7'h5B; wr_data1 = 8'hFF; wr_data2 = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int k = 0; k < 12 * BIT && !seen; k++) begin
      @(negedge clk);
      if (fall_idx >= 4 && scl_oe) seen = 1;
    end
    check_eq("rst_mid_reach", seen, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_mid_scl_oe", scl_oe, 0);
    check_eq("rst_mid_sda_oe", sda_oe, 0);
    check_eq("rst_mid_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_rd1 = '0;
    model_rd2 = '0;
    check_eq("rst_mid_rd1", rd_data1, model_rd1);
    check_eq("rst_mid_nack", nack, 0);
    $display("txn %0d reset asserted mid-address", txn_no);
    txn_no++;
  endtask

  initial begin
    repeat (4) @(negedge clk);
    check_eq("rst_scl_oe", scl_oe, 0);
    check_eq("rst_sda_oe", sda_oe, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_nack", nack, 0);
    check_eq("rst_rd1", rd_data1, 0);
    check_eq("rst_rd2", rd_data2, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(1'b0, 7'h5B, 8'hA5, 8'h3C, 1, 1, 1, 0, 0);
    run_txn(1'b1, 7'h5B, 8'hC3, 8'h7E, 1, 1, 1, 0, 0);
    run_txn(1'b0, 7'h12, 8'h55, 8'hAA, 0, 1, 1, 0, 0);
    run_txn(1'b0, 7'h2A, 8'h0F, 8'hF0, 1, 0, 1, 0, 0);
    run_txn(1'b1, 7'h12, 8'h11, 8'h22, 0, 1, 1, 0, 0);
    run_txn(1'b0, 7'h5B, 8'h81, 8'h18, 1, 1, 1, 1, 0);
    run_txn(1'b0, 7'h5B, 8'hA5, 8'h3C, 1, 1, 1, 0, 1);
    for (int i = 0; i < 20; i++) begin
      run_txn(1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom), 8'($urandom),
              $urandom_range(0, 7) != 0, $urandom_range(0, 5) != 0, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'b0);
    end
    reset_mid();
    run_txn(1'b1, 7'h33, 8'h96, 8'h69, 1, 1, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
